// File: rtl/sdio_cmd_pkg.sv
// sdio_cmd_pkg: shared constants, state encoding and CRC7 step for the SDIO command path
package sdio_cmd_pkg;
  localparam int FRAME_BITS = 48;
  localparam int CRC_BITS = 7;
  localparam logic [CRC_BITS-1:0] CRC7_POLY = 7'h09;
  localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);
  localparam logic [5:0] CRC_END = 6'(FRAME_BITS - 8);
  localparam int ST_CRC_ERR = 0;
  localparam int ST_END_ERR = 1;
  localparam int ST_DIR_ERR = 2;
  localparam int ST_BUSY = 3;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  function automatic logic [CRC_BITS-1:0] crc7_step(input logic [CRC_BITS-1:0] c, input logic d);
    return {c[CRC_BITS-2:0], 1'b0} ^ ({CRC_BITS{c[CRC_BITS-1] ^ d}} & CRC7_POLY);
  endfunction
endpackage

// File: rtl/sdio_crc7.sv
// sdio_crc7: serial CRC7 (x^7+x^3+1), clr zeroes the remainder before an optional same-cycle feed
module sdio_crc7
  import sdio_cmd_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                din,
  output logic [CRC_BITS-1:0] crc
);
  logic [CRC_BITS-1:0] base;
  assign base = clr ? '0 : crc;
  always_ff @(posedge clk)
    if (rst) crc <= '0;
    else crc <= en ? crc7_step(base, din) : base;
endmodule

// File: rtl/sdio_cmd_frame_rx.sv
// sdio_cmd_frame_rx: oversampling deframer for 48-bit SDIO host-to-card command tokens
module sdio_cmd_frame_rx
  import sdio_cmd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sd_en,
  input  logic                sd_clk,
  input  logic                cmd_i,
  output logic [7:0]          cmd_o,
  output logic [31:0]         arg_o,
  output logic [CRC_BITS-1:0] crc_o,
  output logic                finsh_o,
  output logic [7:0]          status
);
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES:0]   cmd_sync;
  logic                   clk_d;
  logic                   strobe;
  logic                   cmd_s;
  logic                   shift;
  logic                   load;
  state_t                 state;
  state_t                 state_n;
  logic [5:0]             bitcnt;
  logic [FRAME_BITS-2:0]  sr;
  logic [FRAME_BITS-1:0]  frame;
  logic [2:0]             err;
  logic [3:0]             frame_cnt;
  logic [CRC_BITS-1:0]    crc;
  assign strobe = clk_sync[SYNC_STAGES-1] & ~clk_d;
  assign cmd_s = cmd_sync[SYNC_STAGES];
  assign frame = {sr, cmd_s};
  assign finsh_o = state == DONE;
  assign status = {frame_cnt, state != IDLE, err};
  always_comb begin
    state_n = !sd_en ? IDLE :
              state == IDLE ? (strobe && !cmd_s ? SHIFT : IDLE) :
              state == SHIFT ? (strobe && bitcnt == LAST_BIT ? DONE : SHIFT) : IDLE;
    shift = strobe && state_n != IDLE;
    load = state == SHIFT && state_n == DONE;
  end
  sdio_crc7 u_crc (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .en (shift && bitcnt < CRC_END),
    .din(cmd_s),
    .crc(crc)
  );
  always_ff @(posedge clk)
    if (rst) begin
      clk_sync <= '1;
      cmd_sync <= '1;
      clk_d <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], sd_clk};
      cmd_sync <= {cmd_sync[SYNC_STAGES-1:0], cmd_i};
      clk_d <= clk_sync[SYNC_STAGES-1];
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bitcnt <= '0;
      sr <= '0;
      cmd_o <= '0;
      arg_o <= '0;
      crc_o <= '0;
      err <= '0;
      frame_cnt <= '0;
    end else begin
      state <= state_n;
      bitcnt <= state_n == IDLE ? '0 : bitcnt + {5'd0, shift};
      if (shift) sr <= frame[FRAME_BITS-2:0];
      if (load) begin
        cmd_o <= frame[47:40];
        arg_o <= frame[39:8];
        crc_o <= frame[7:1];
        err[ST_CRC_ERR] <= crc != frame[7:1];
        err[ST_END_ERR] <= !frame[0];
        err[ST_DIR_ERR] <= !frame[46];
        frame_cnt <= frame_cnt + 4'd1;
      end
    end
endmodule

// File: tb/tb_sdio_cmd_frame_rx.sv
// tb_sdio_cmd_frame_rx: randomized self-checking bench against a queue-based frame model
module tb_sdio_cmd_frame_rx;
  logic        clk = 0;
  logic        rst = 1;
  logic        sd_en = 1;
  logic        sd_clk = 1;
  logic        cmd_i = 1;
  logic [7:0]  cmd_o;
  logic [31:0] arg_o;
  logic [6:0]  crc_o;
  logic        finsh_o;
  logic [7:0]  status;
  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] arg;
    logic [6:0]  crc;
    logic [7:0]  st;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int fcnt = 0;
  int phase = 1;
  logic prev_f = 0;
  localparam logic [47:0] CMD0 = 48'h40_00000000_95;
  localparam logic [47:0] CMD8 = 48'h48_000001AA_87;
  always #5 clk = ~clk;
  sdio_cmd_frame_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .sd_en(sd_en),
    .sd_clk(sd_clk),
    .cmd_i(cmd_i),
    .cmd_o(cmd_o),
    .arg_o(arg_o),
    .crc_o(crc_o),
    .finsh_o(finsh_o),
    .status(status)
  );
  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] crc7_ref(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
    return r[6:0];
  endfunction
  function automatic logic [47:0] mk(input logic [7:0] c, input logic [31:0] a);
    return {c, a, crc7_ref({c, a}), 1'b1};
  endfunction
  task automatic push_exp(input logic [47:0] f);
    exp_t x;
    fcnt = (fcnt + 1) % 16;
    x.cmd = f[47:40];
    x.arg = f[39:8];
    x.crc = f[7:1];
    x.st = {4'(fcnt), 1'b1, ~f[46], ~f[0], crc7_ref(f[47:8]) != f[7:1]};
    exp_q.push_back(x);
  endtask
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #(phase);
  endtask
  task automatic sd_bit(input logic b, input int half);
    sd_clk = 0;
    cmd_i = b;
    wait_clk(half);
    sd_clk = 1;
    wait_clk(half);
  endtask
  task automatic send(input logic [47:0] f, input int half, input int idle);
    push_exp(f);
    for (int i = 47; i >= 0; i--) sd_bit(f[i], half);
    repeat (idle) sd_bit(1'b1, half);
  endtask
  task automatic send_part(input logic [47:0] f, input int half, input int nbits);
    for (int i = 47; i > 47 - nbits; i--) sd_bit(f[i], half);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_cmd"}, 48'(cmd_o), 0);
    chk({tag, "_arg"}, 48'(arg_o), 0);
    chk({tag, "_crc"}, 48'(crc_o), 0);
    chk({tag, "_status"}, 48'(status), 0);
    chk({tag, "_finsh"}, 48'(finsh_o), 0);
  endtask
  always @(negedge clk) begin
    if (finsh_o) begin
      chk("pulse_width", 48'(prev_f), 0);
      chk("pulse_expected", 48'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("p_cmd", 48'(cmd_o), 48'(e.cmd));
        chk("p_arg", 48'(arg_o), 48'(e.arg));
        chk("p_crc", 48'(crc_o), 48'(e.crc));
        chk("p_status", 48'(status), 48'(e.st));
      end
    end
    prev_f = finsh_o;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [47:0] f;
    int half;
    int k;
    wait_clk(4);
    chk_zero("reset");
    rst = 0;
    wait_clk(2);
    send(CMD0, 4, 2);
    chk("cmd0_cmd", 48'(cmd_o), 48'h40);
    chk("cmd0_arg", 48'(arg_o), 0);
    chk("cmd0_crc", 48'(crc_o), 48'h4A);
    chk("cmd0_status", 48'(status), 48'h10);
    rst = 1;
    wait_clk(2);
    rst = 0;
    fcnt = 0;
    wait_clk(2);
    send(CMD8, 4, 2);
    chk("cmd8_arg", 48'(arg_o), 48'h1AA);
    chk("cmd8_crc", 48'(crc_o), 48'h43);
    send(48'h51_00000000_55, 4, 2);
    chk("cmd17_cmd", 48'(cmd_o), 48'h51);
    chk("cmd17_crc", 48'(crc_o), 48'h2A);
    chk("cmd17_status", 48'(status), 48'h20);
    send(48'h48_000001AA_85, 4, 2);
    chk("badcrc_err", 48'(status[0]), 1);
    chk("badcrc_arg", 48'(arg_o), 48'h1AA);
    send(48'h40_00000000_94, 4, 2);
    chk("endbit_err", 48'(status[2:0]), 48'h2);
    send(mk(8'h00, 32'h0), 4, 2);
    chk("dir_err", 48'(status[2]), 1);
    send_part(CMD8, 4, 20);
    sd_en = 0;
    wait_clk(2);
    repeat (3) sd_bit(1'b1, 4);
    chk("abort_busy", 48'(status[3]), 0);
    sd_en = 1;
    sd_bit(1'b1, 4);
    send(CMD0, 4, 2);
    chk("abort_cnt", 48'(status[7:4]), 48'(fcnt));
    send_part(CMD8, 4, 20);
    rst = 1;
    wait_clk(3);
    chk_zero("rst_abort");
    fcnt = 0;
    rst = 0;
    repeat (2) sd_bit(1'b1, 4);
    phase = $urandom_range(1, 9);
    wait_clk(1);
    repeat (17) send(CMD0, 2, 0);
    repeat (2) sd_bit(1'b1, 2);
    chk("wrap_status", 48'(status), 48'h10);
    repeat (12) begin
      half = $urandom_range(2, 6);
      f = mk({2'b01, 6'($urandom_range(0, 63))}, $urandom);
      k = $urandom_range(0, 3);
      if (k == 1) f[1 + $urandom_range(0, 6)] ^= 1'b1;
      if (k == 2) f[0] = 1'b0;
      if (k == 3) f[46] = 1'b0;
      send(f, half, 1);
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain", 48'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdio_cmd_frame_rx.md
Name: sdio_cmd_frame_rx

Overview:
Upstream receive stage of the SDIO command path. Oversamples the bus SD clock and CMD line in the system clock domain and deframes 48-bit host-to-card command tokens. Checks CRC7 and framing, then presents index, argument and status with a one-cycle finish pulse. The byte-packing controller consumes these outputs and pushes them into the rx FIFO.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on sd_clk and cmd_i (legal range 2..4).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sd_en  in  1  receiver enable; 0 forces idle
sd_clk  in  1  SD bus clock, asynchronous; must satisfy f(sd_clk) <= f(clk)/4
cmd_i  in  1  SD CMD line, asynchronous
cmd_o  out  8  first frame byte {start, dir, index[5:0]}
arg_o  out  32  command argument, MSB first on wire
crc_o  out  7  CRC7 as received
finsh_o  out  1  one-cycle pulse; frame outputs valid
status  out  8  [0] crc_err, [1] end_err, [2] dir_err (dir bit = 0), [3] busy, [7:4] frame_cnt

Behaviour:
- Reset (rst=1 at posedge clk): state IDLE, bit counter 0, CRC 0. Outputs cmd_o, arg_o, crc_o, status and finsh_o are all 0. Synchronizer flops reset to 1 (bus idle high).
- Synchronization:
  - sd_clk and cmd_i each pass through SYNC_STAGES flops.
  - cmd_i gets one extra flop so it stays aligned with the edge detector.
  - A sample strobe fires on a 0->1 transition of synchronized sd_clk. All bus data is taken only on the strobe.
- FSM states:
  - IDLE: on a strobe with cmd=0, capture the start bit. Go to SHIFT with bitcnt=1 and CRC cleared, then fed with 0.
  - SHIFT:
    - On each strobe, shift cmd into a 48-bit register and increment bitcnt.
    - Bits 0..39 feed the CRC7.
    - When the strobe captures bit 47 (bitcnt reaches 48), go to DONE.
  - DONE: lasts exactly one clk. Drive outputs and status[2:0], pulse finsh_o=1, increment frame_cnt, return to IDLE.
- Latency: finsh_o is high exactly 1 clk after the clk in which the bit-47 strobe was registered.
- Output holding:
  - cmd_o, arg_o, crc_o and status[2:0] update only in DONE and hold until the next DONE.
  - busy is 1 in SHIFT and DONE.
- Error checks:
  - CRC7: polynomial x^7+x^3+1, initial value 0, covering bits 47..8 as sent on the wire. crc_err = (computed != received bits 7:1).
  - end_err = (bit 0 != 1).
  - dir_err = (bit 46 == 0).
  - A frame with errors still completes and pulses finsh_o; the consumer decides what to do with it.
- Boundary and abort cases:
  - frame_cnt is 4 bits and wraps 15->0.
  - sd_en=0 in any state: immediately go to IDLE and abort any partial frame. No finsh_o pulse; outputs and frame_cnt are held.
  - rst=1 mid-frame: abort and return to reset values. Mid-frame resync is not attempted; after an abort, the receiver waits for the next low cmd on a strobe.
  - Bus idle high in IDLE: no activity.
- The strobe is never acted on in DONE. This is safe because of the clk/4 constraint.

Decomposition:
- Package sdio_cmd_pkg:
  - FRAME_BITS=48, CRC_BITS=7, CRC7_POLY=7'h09.
  - FSM state encodings (IDLE, SHIFT, DONE).
  - Status bit index constants (ST_CRC_ERR=0, ST_END_ERR=1, ST_DIR_ERR=2, ST_BUSY=3).
- Sub-module sdio_crc7: serial CRC7 with ports clk, rst, clr, en, din, crc[6:0]. It will be reused by the future response transmitter.

Test Plan:
- CMD0 frame 0x40_00000000_95, sd_clk = clk/8 -> one finsh_o pulse; cmd_o=0x40, arg_o=0, crc_o=0x4A, status=0x10.
- CMD8 frame 0x48_000001AA_87 followed by CMD17 frame 0x51_00000000_55 -> two pulses. First: arg_o=0x000001AA, crc_o=0x43. Second: cmd_o=0x51, crc_o=0x2A, frame_cnt=2, no error bits.
- CMD8 with last byte 0x85 (CRC corrupted) -> finsh_o pulses with status[0]=1; cmd_o and arg_o still updated.
- CMD0 with end bit 0 (last byte 0x94) -> status[1]=1 and status[0]=0. Frame with dir bit 0 (first byte 0x00) -> status[2]=1.
- Drop sd_en after 20 bits of CMD8, restore it, then send CMD0 -> no pulse for the aborted frame; next pulse reports CMD0 with frame_cnt incremented by 1 only. Repeat the abort with rst=1 mid-frame -> all outputs 0.
- sd_clk at exactly clk/4 with random phase, 17 consecutive CMD0 frames -> 17 pulses with no errors; frame_cnt wraps to 1.
